password_loader: RTL

- Upstream feeder for the parallel password cracker top level.
- Accepts a character stream over a valid/ready byte interface, validates and normalises each character against the 36-symbol charset, and assembles a PW_LEN-character target.
- Presents the target, stable, on the cracker's password input and issues a one-cycle start pulse.
- Then waits for the cracker's aggregate done and reports found/not-found once before accepting the next password.

---
 rtl/password_loader_pkg.sv | 20 ++
 rtl/password_loader_char_normalize.sv | 27 ++
 rtl/password_loader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/password_loader_pkg.sv
// Shared constants for the password loader and the cracker front end:
// charset bounds, case-fold offset, charset size and FSM state encoding.
package password_loader_pkg;

  localparam logic [7:0] DIGIT_LO  = 8'h30;
  localparam logic [7:0] DIGIT_HI  = 8'h39;
  localparam logic [7:0] UPPER_LO  = 8'h41;
  localparam logic [7:0] UPPER_HI  = 8'h5A;
  localparam logic [7:0] LOWER_LO  = 8'h61;
  localparam logic [7:0] LOWER_HI  = 8'h7A;
  localparam logic [7:0] CASE_FOLD = 8'h20;

  localparam int CHARSET_SIZE = 36;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_LAUNCH  = 2'd1;
  localparam logic [1:0] ST_ARM     = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

endpackage

// File: rtl/password_loader_char_normalize.sv
// Combinational charset check for one character: digits and lowercase
// pass through, uppercase is folded to lowercase, anything else is illegal.
module char_normalize
  import password_loader_pkg::*;
#(
  parameter int CHAR_W = 8
) (
  input  logic [CHAR_W-1:0] in_char,
  output logic [CHAR_W-1:0] norm_char,
  output logic              legal
);

  // Classify the character against the three charset ranges and fold case.
  always_comb begin
    legal     = 1'b0;
    norm_char = in_char;
    if (in_char >= CHAR_W'(DIGIT_LO) && in_char <= CHAR_W'(DIGIT_HI)) begin
      legal = 1'b1;
    end else if (in_char >= CHAR_W'(LOWER_LO) && in_char <= CHAR_W'(LOWER_HI)) begin
      legal = 1'b1;
    end else if (in_char >= CHAR_W'(UPPER_LO) && in_char <= CHAR_W'(UPPER_HI)) begin
      legal     = 1'b1;
      norm_char = in_char + CHAR_W'(CASE_FOLD);
    end
  end

endmodule

// File: rtl/password_loader.sv
// Upstream feeder for the password cracker: collects and normalises a
// PW_LEN-character target over a valid/ready byte stream, launches a search
// with a one-cycle start pulse, then reports the cracker's result once.
module password_loader
  import password_loader_pkg::*;
#(
  parameter int PW_LEN       = 4,
  parameter int CHAR_W       = 8,
  parameter int IDLE_TIMEOUT = 1000,
  parameter int CNT_W        = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHAR_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     crack_done,
  input  logic                     crack_found,
  output logic [PW_LEN*CHAR_W-1:0] password_out,
  output logic                     crack_start,
  output logic                     busy,
  output logic                     result_valid,
  output logic                     result_found,
  output logic                     err_char,
  output logic                     err_timeout
);

  localparam int IDX_W = (PW_LEN > 1) ? $clog2(PW_LEN) : 1;

  logic [1:0]               state;
  logic [IDX_W-1:0]         idx;
  logic [CNT_W-1:0]         cnt;
  logic [PW_LEN*CHAR_W-1:0] asm_buf;
  logic [PW_LEN*CHAR_W-1:0] asm_next;
  logic [CHAR_W-1:0]        norm_char;
  logic                     char_legal;
  logic                     accept;
  logic                     last_char;
  logic                     timeout_hit;

  char_normalize #(.CHAR_W(CHAR_W)) u_norm (
    .in_char  (in_data),
    .norm_char(norm_char),
    .legal    (char_legal)
  );

  assign in_ready    = (state == ST_COLLECT);
  assign busy        = (state != ST_COLLECT);
  assign crack_start = (state == ST_LAUNCH);
  assign accept      = in_valid && in_ready;
  assign last_char   = (idx == IDX_W'(PW_LEN - 1));
  assign timeout_hit = in_ready && !accept && (idx != '0) &&
                       (cnt == CNT_W'(IDLE_TIMEOUT - 1));

  // Assembly buffer with the incoming normalised character dropped into its
  // slot; the first character lands in the most significant position.
  always_comb begin
    asm_next = asm_buf;
    for (int k = 0; k < PW_LEN; k++) begin
      if (idx == IDX_W'(k)) begin
        asm_next[(PW_LEN-k)*CHAR_W-1 -: CHAR_W] = norm_char;
      end
    end
  end

  // Inter-byte idle counter: runs only while a partial password is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept || timeout_hit || !in_ready || idx == '0) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Main sequencer: collect, launch, arm on done low, run until done high.
  // password_out is written on the edge that enters LAUNCH so the target is
  // already stable while crack_start is high, and never changes mid-search.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_COLLECT;
      idx          <= '0;
      asm_buf      <= '0;
      password_out <= '0;
      result_valid <= 1'b0;
      result_found <= 1'b0;
      err_char     <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      err_char     <= 1'b0;
      err_timeout  <= 1'b0;
      case (state)
        ST_COLLECT: begin
          if (accept) begin
            if (!char_legal) begin
              err_char <= 1'b1;
              idx      <= '0;
              asm_buf  <= '0;
            end else if (last_char) begin
              password_out <= asm_next;
              asm_buf      <= '0;
              idx          <= '0;
              state        <= ST_LAUNCH;
            end else begin
              asm_buf <= asm_next;
              idx     <= idx + IDX_W'(1);
            end
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
            idx         <= '0;
            asm_buf     <= '0;
          end
        end
        ST_LAUNCH: begin
          state <= ST_ARM;
        end
        ST_ARM: begin
          if (!crack_done) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (crack_done) begin
            result_valid <= 1'b1;
            result_found <= crack_found;
            idx          <= '0;
            state        <= ST_COLLECT;
          end
        end
        default: begin
          state <= ST_COLLECT;
        end
      endcase
    end
  end

endmodule
